seg_scan_decoder: RTL and testbench

Receiving end of the two-digit multiplexed seven-segment bus driven by the counter top level. It samples the active-low anode/segment lines, waits for each scanned digit to settle, and converts the patterns back into BCD digits and a binary value. One frame is reported per complete scan. Used as an on-board self-check of the display path and as the bench monitor for display-producing designs.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg7_to_bin.sv | 29 ++
 rtl/seg_scan_decoder.sv | 168 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment display path.
// Segment patterns are active-low in g,f,e,d,c,b,a order (bit 6 = g).
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] ANODE_ONES = 8'hFE;
    localparam logic [7:0] ANODE_TENS = 8'hFD;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } scan_state_t;

    // tens*10 + ones built from shifts so it stays a 7-bit add chain
    function automatic logic [6:0] bcd_value(input logic [3:0] tens, input logic [3:0] ones);
        return {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, ones};
    endfunction

endpackage

// File: rtl/seg7_to_bin.sv
// Active-low seven-segment pattern to BCD digit; is_digit_o is low for
// anything that is not one of the ten digit glyphs.
module seg7_to_bin
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       is_digit_o
);

    always_comb begin
        digit_o    = 4'd0;
        is_digit_o = 1'b1;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: is_digit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a two-digit multiplexed active-low display bus, captures each digit
// once it has settled, and reports one BCD/binary frame per complete scan.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Anode,
    input  logic [7:0] Display,
    output logic [3:0] Ones,
    output logic [3:0] Tens,
    output logic [6:0] Value,
    output logic       Value_Valid,
    output logic       Seg_Error,
    output logic [1:0] Dbg_State
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic        unused_dp;
    logic [7:0]  anode_q;
    logic [6:0]  disp_q;
    logic [14:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    scan_state_t state_q, state_d;

    logic [3:0]  ones_slot_q, ones_slot_d;
    logic [3:0]  tens_slot_q, tens_slot_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [6:0]  value_q, value_d;
    logic        vv_q, vv_d;
    logic        err_q, err_d;

    logic        active;
    logic        changed;
    logic        slot;
    logic        capture_en;
    logic [3:0]  digit;
    logic        is_digit;

    assign unused_dp = Display[7];

    // Stage 0 plus the previous sample used for change detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            anode_q <= 8'hFF;
            disp_q  <= 7'h7F;
            prev_q  <= '1;
            cnt_q   <= 8'd0;
        end else begin
            anode_q <= Anode;
            disp_q  <= Display[6:0];
            prev_q  <= {anode_q, disp_q};
            cnt_q   <= cnt_d;
        end
    end

    assign active  = (anode_q[7:2] == 6'h3F) && (anode_q[1] ^ anode_q[0]);
    assign changed = ({anode_q, disp_q} != prev_q);
    assign slot    = anode_q[0];

    always_comb begin
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = 8'd0;
        end else if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q < STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving CAPTURE straight to SETTLE on a change keeps the next dwell from being lost
    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLE:  if (cnt_d == STABLE_MAX) state_d = CAPTURE;
            CAPTURE: state_d = (!active || changed) ? SETTLE : HOLD;
            HOLD:    if (!active || changed) state_d = SETTLE;
            default: state_d = SETTLE;
        endcase
    end

    always_comb begin
        capture_en = (state_q == SETTLE) && (cnt_d == STABLE_MAX);
        Dbg_State  = state_q;
    end

    seg7_to_bin u_seg7_to_bin (
        .seg_i      (disp_q),
        .digit_o    (digit),
        .is_digit_o (is_digit)
    );

    // Frame publication and slot capture can share an edge; capture wins on seen_d
    always_comb begin
        ones_slot_d = ones_slot_q;
        tens_slot_d = tens_slot_q;
        seen_d      = seen_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        value_d     = value_q;
        vv_d        = 1'b0;
        err_d       = 1'b0;
        if (&seen_q) begin
            ones_d  = ones_slot_q;
            tens_d  = tens_slot_q;
            value_d = bcd_value(tens_slot_q, ones_slot_q);
            vv_d    = 1'b1;
            seen_d  = '0;
        end
        if (capture_en) begin
            if (is_digit) begin
                if (slot) begin
                    tens_slot_d = digit;
                end else begin
                    ones_slot_d = digit;
                end
                seen_d[slot] = 1'b1;
            end else begin
                err_d        = 1'b1;
                seen_d[slot] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ones_slot_q <= 4'd0;
            tens_slot_q <= 4'd0;
            seen_q      <= '0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            value_q     <= 7'd0;
            vv_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ones_slot_q <= ones_slot_d;
            tens_slot_q <= tens_slot_d;
            seen_q      <= seen_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            value_q     <= value_d;
            vv_q        <= vv_d;
            err_q       <= err_d;
        end
    end

    assign Ones        = ones_q;
    assign Tens        = tens_q;
    assign Value       = value_q;
    assign Value_Valid = vv_q;
    assign Seg_Error   = err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: drives anode/segment dwells and checks reported
// frames against an expected queue filled as each frame is driven.
module tb_seg_scan_decoder;

    localparam int S = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Anode;
    logic [7:0] Display;
    logic [3:0] Ones;
    logic [3:0] Tens;
    logic [6:0] Value;
    logic       Value_Valid;
    logic       Seg_Error;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];
    logic [6:0]  seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_scan_decoder #(.NUM_DIGITS(2), .STABLE_CYCLES(S)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Anode       (Anode),
        .Display     (Display),
        .Ones        (Ones),
        .Tens        (Tens),
        .Value       (Value),
        .Value_Valid (Value_Valid),
        .Seg_Error   (Seg_Error),
        .Dbg_State   (dbg_state)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] seg_of(input int d);
        return {1'b1, seg_tab[d]};
    endfunction

    function automatic logic [14:0] frame_word(input int t, input int o);
        logic [3:0] tt;
        logic [3:0] oo;
        logic [6:0] vv;
        tt = 4'(t);
        oo = 4'(o);
        vv = 7'(t * 10 + o);
        return {tt, oo, vv};
    endfunction

    // Advance n cycles, sampling 1 ns after each edge and logging DUT events
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            if (Value_Valid === 1'b1) obs_q.push_back({Tens, Ones, Value});
            if (Seg_Error === 1'b1) err_seen++;
        end
    endtask

    task automatic dwell(input logic [7:0] an, input logic [7:0] disp, input int n);
        Anode   = an;
        Display = disp;
        tick(n);
    endtask

    task automatic apply_reset();
        Reset   = 1'b1;
        Anode   = 8'hFF;
        Display = 8'hFF;
        tick(2);
        Reset    = 1'b0;
        exp_q.delete();
        obs_q.delete();
        err_seen = 0;
    endtask

    task automatic test_reset();
        logic [14:0] e, o;
        Reset   = 1'b1;
        Anode   = 8'hFE;
        Display = 8'hC0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if ({Ones, Tens, Value, Value_Valid, Seg_Error, dbg_state} !== 22'd0) begin
                errors++;
                $display("FAIL reset_outputs: got ones=%0d tens=%0d value=%0d vv=%b err=%b state=%0d, expected all 0",
                         Ones, Tens, Value, Value_Valid, Seg_Error, dbg_state);
            end
        end
        Reset = 1'b0;
        obs_q.delete();
        err_seen = 0;
        exp_q.push_back(frame_word(4, 0));
        tick(10);
        dwell(8'hFD, seg_of(4), 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_release_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_release_value: got %h, expected %h", o, e);
            end
        end
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL reset_release_err: got %0d errors, expected 0", err_seen);
        end
    endtask

    task automatic test_latency();
        int first_err;
        int first_vv;
        logic [14:0] e, o;
        apply_reset();
        Anode     = 8'hFE;
        Display   = 8'hFF;
        first_err = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (Seg_Error === 1'b1 && first_err == 0) first_err = i;
        end
        checks++;
        if (first_err != S + 1) begin
            errors++;
            $display("FAIL err_latency: got cycle %0d, expected %0d", first_err, S + 1);
        end
        checks++;
        if (err_seen != 1) begin
            errors++;
            $display("FAIL err_single_pulse: got %0d pulses, expected 1", err_seen);
        end
        apply_reset();
        dwell(8'hFD, seg_of(3), 10);
        exp_q.push_back(frame_word(3, 5));
        Anode    = 8'hFE;
        Display  = seg_of(5);
        first_vv = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (Value_Valid === 1'b1 && first_vv == 0) first_vv = i;
        end
        checks++;
        if (first_vv != S + 2) begin
            errors++;
            $display("FAIL vv_latency: got cycle %0d, expected %0d", first_vv, S + 2);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL latency_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL latency_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_alternate();
        logic [14:0] e, o;
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(frame_word(3, 5));
            dwell(8'hFE, 8'h92, 20);
            dwell(8'hFD, 8'hB0, 20);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL alt_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alt_value: got %h, expected %h", o, e);
            end
        end
        checks++;
        if ({Tens, Ones, Value} !== frame_word(3, 5)) begin
            errors++;
            $display("FAIL alt_hold: got tens=%0d ones=%0d value=%0d, expected 3 5 35", Tens, Ones, Value);
        end
    endtask

    task automatic test_glitch();
        logic [14:0] e, o;
        apply_reset();
        for (int g = 0; g < 3; g++) begin
            dwell(8'hFD, seg_of(2), 10);
            dwell(8'hFE, seg_of(1), S - 1);
        end
        dwell(8'hFD, seg_of(2), 10);
        checks++;
        if (obs_q.size() != 0 || err_seen != 0) begin
            errors++;
            $display("FAIL glitch_reject: got %0d frames %0d errors, expected 0 0", obs_q.size(), err_seen);
        end
        exp_q.push_back(frame_word(2, 1));
        dwell(8'hFE, seg_of(1), 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL glitch_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL glitch_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_bad_pattern();
        logic [14:0] e, o;
        apply_reset();
        dwell(8'hFE, 8'hFF, 10);
        dwell(8'hFD, seg_of(6), 10);
        dwell(8'hFE, 8'h7F, 10);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bad_no_frame: got %0d frames, expected 0", obs_q.size());
        end
        exp_q.push_back(frame_word(6, 8));
        dwell(8'hFE, seg_of(8), 10);
        exp_q.push_back(frame_word(1, 5));
        dwell(8'hFD, seg_of(1), 10);
        dwell(8'hFE, 8'h12, 10);
        checks++;
        if (err_seen != 2) begin
            errors++;
            $display("FAIL bad_err_count: got %0d errors, expected 2", err_seen);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bad_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bad_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_blank_anode();
        logic [14:0] e, o;
        apply_reset();
        exp_q.push_back(frame_word(9, 2));
        dwell(8'hFE, seg_of(2), 10);
        dwell(8'hFC, 8'hFF, 10);
        dwell(8'hFF, 8'hFF, 10);
        dwell(8'hFB, seg_of(3), 10);
        checks++;
        if (obs_q.size() != 0 || err_seen != 0) begin
            errors++;
            $display("FAIL blank_ignored: got %0d frames %0d errors, expected 0 0", obs_q.size(), err_seen);
        end
        dwell(8'hFD, seg_of(9), 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL blank_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL blank_value: got %h, expected %h", o, e);
            end
        end
    endtask

    task automatic test_sweep();
        int v;
        logic [14:0] e, o;
        apply_reset();
        for (int n = 0; n <= 100; n++) begin
            v = n % 100;
            exp_q.push_back(frame_word(v / 10, v % 10));
            dwell(8'hFE, seg_of(v % 10), $urandom_range(S + 2, S + 6));
            dwell(8'hFD, seg_of(v / 10), $urandom_range(S + 2, S + 6));
        end
        tick(3);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sweep_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sweep_value: got %h, expected %h", o, e);
            end
        end
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL sweep_err: got %0d errors, expected 0", err_seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [14:0] e, o;
        apply_reset();
        exp_q.push_back(frame_word(7, 4));
        dwell(8'hFE, seg_of(4), 10);
        dwell(8'hFD, seg_of(7), 10);
        dwell(8'hFE, seg_of(4), 10);
        Reset = 1'b1;
        tick(1);
        checks++;
        if ({Ones, Tens, Value, Value_Valid, Seg_Error} !== 17'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got ones=%0d tens=%0d value=%0d vv=%b err=%b, expected all 0",
                     Ones, Tens, Value, Value_Valid, Seg_Error);
        end
        Reset = 1'b0;
        dwell(8'hFD, seg_of(7), 10);
        exp_q.push_back(frame_word(7, 2));
        dwell(8'hFE, seg_of(2), 10);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_frames: got %0d frames, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midreset_value: got %h, expected %h", o, e);
            end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        Anode   = 8'hFE;
        Display = 8'hC0;
        test_reset();
        test_latency();
        test_alternate();
        test_glitch();
        test_bad_pattern();
        test_blank_anode();
        test_sweep();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
